// File: rtl/gray_code_counter.sv
// rtl/gray_code_counter.sv - registered N-bit Gray-code up/down counter with binary load
//
// Purpose:
//   Keeps an internal binary count and presents its Gray encoding on a
//   registered output. Counted steps change exactly one bit of gray_value,
//   so a downstream Gray-to-binary stage can sample it safely.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          asynchronous active-high reset (clears count and pulses)
//   en           count enable, one step per clock when high
//   up_dn        step direction: 1 = increment, 0 = decrement
//   load         synchronous load strobe, wins over en
//   load_value   binary value taken by load
//   gray_value   registered Gray code of the binary count
//   gray_update  one-cycle pulse, gray_value was written at this edge
//   wrap         one-cycle pulse, a counted step crossed the 0 / 2^N-1 boundary

module gray_code_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [N-1:0] load_value,
  output logic [N-1:0] gray_value,
  output logic         gray_update,
  output logic         wrap
);

  localparam logic [N-1:0] step_one = N'(1);

  logic [N-1:0] bin_q;
  logic [N-1:0] bin_d;
  logic         wrap_d;
  logic         update_d;

  // Next-state: load beats en beats hold. A load never flags wrap, even if
  // the loaded value sits on the boundary.
  always_comb begin
    bin_d    = bin_q;
    wrap_d   = 1'b0;
    update_d = 1'b0;
    if (load) begin
      bin_d    = load_value;
      update_d = 1'b1;
    end else if (en) begin
      update_d = 1'b1;
      if (up_dn) begin
        bin_d  = bin_q + step_one;
        wrap_d = &bin_q;
      end else begin
        bin_d  = bin_q - step_one;
        wrap_d = ~|bin_q;
      end
    end
  end

  // Gray code is taken from the next binary value so that bin_q and
  // gray_value are updated on the same edge with no extra pipeline stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q       <= '0;
      gray_value  <= '0;
      gray_update <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      bin_q       <= bin_d;
      gray_value  <= bin_d ^ (bin_d >> 1);
      gray_update <= update_d;
      wrap        <= wrap_d;
    end
  end

endmodule
